trace_serialiser: RTL and testbench
===================================

Name: trace_serialiser

Overview:
- Sits directly downstream of the trace unit top level and consumes the completed trace records it produces, one record per cycle at most.
- Buffers records in a small FIFO and serialises each record into OUT_WIDTH-bit beats on a valid/ready stream toward the off-chip or debug transport.
- The upstream trace path cannot be stalled. Records arriving while the FIFO is full are dropped and counted.

Parameters:
- TRACE_WIDTH, 96, width of one packed trace record.
- OUT_WIDTH, 32, width of one output beat. Must be ≥ 32.
- FIFO_DEPTH, 4, number of records the FIFO holds. Power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- trace_valid_i  in  1  trace_data_i holds a new record this cycle.
- trace_data_i  in  TRACE_WIDTH  packed trace record.
- out_valid_o  out  1  out_data_o holds a valid beat.
- out_data_o  out  OUT_WIDTH  current beat.
- out_last_o  out  1  current beat is the final beat of its record.
- out_ready_i  in  1  downstream accepts the beat when out_valid_o is also high.
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  records held in the FIFO, excluding the record being sent.
- overflow_count_o  out  16  number of dropped records, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk.
- Reset state:
  - out_valid_o=0, out_data_o=0, out_last_o=0.
  - fifo_level_o=0, overflow_count_o=0.
  - FIFO is emptied and the state machine enters IDLE.
- Reset mid-record: the partially sent record is discarded. No further beats of it appear after reset is released.
- BEATS = ceil(TRACE_WIDTH/OUT_WIDTH).
  - Beat k carries record bits [k*OUT_WIDTH +: OUT_WIDTH].
  - Bits above TRACE_WIDTH-1 are zero-padded.
  - Beat 0 is the least significant slice.
- Push rules:
  - A push occurs at an edge when trace_valid_i=1.
  - The push is accepted if the FIFO is not full, or if a pop occurs at the same edge.
  - Otherwise the record is dropped and overflow_count_o increments, saturating at 16'hFFFF.
- FIFO ordering: strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: out_valid_o=0. If the FIFO is non-empty at an edge: pop the head into the shift register, set beat_cnt=0 and go to SEND.
  - SEND: out_valid_o=1, out_data_o=slice[beat_cnt], out_last_o=(beat_cnt==BEATS-1).
    - On handshake (out_valid_o & out_ready_i) with a non-final beat: beat_cnt++.
    - On handshake of the final beat: if the FIFO is non-empty, pop the next record and stay in SEND with beat_cnt=0, giving no bubble between records. Otherwise go to IDLE.
- No handshake: out_data_o and out_last_o hold stable while out_valid_o=1 and out_ready_i=0.
- Latency: a record pushed at edge N into an idle, empty block gives out_valid_o=1 after edge N+1. There is no bypass path.
- fifo_level_o updates on the same edge as the push or pop. A simultaneous push and pop leaves it unchanged.

Optional Feature:
- Macro: GOURAM_TRACE_HEADER_EN.
- When defined, each record is preceded by one header beat, so BEATS+1 beats go out per record and out_last_o is unchanged, marking the final data beat.
- Header beat contents:
  - [15:0] = 16-bit record sequence number, starting at 0 and incrementing on each final-beat handshake, wrapping at 16'hFFFF→0.
  - [OUT_WIDTH-1] = sticky drop flag: set by any drop, cleared on header-beat handshake. A drop at the same edge as that handshake leaves the flag set.
  - All other bits are 0.
- Both the sequence number and the drop flag reset to 0.
- When not defined: no header beat, no sequence or flag logic.

Test Plan:
1. Single record 96'h0000000C_0000000B_0000000A pushed at edge 0, out_ready_i=1 → out_valid_o=1 after edge 1. Beats 0xA, 0xB, 0xC on consecutive cycles, out_last_o high only on 0xC. out_valid_o=0 afterwards, fifo_level_o=0.
2. Same record, out_ready_i=0 for 5 cycles while beat 1 is presented → out_data_o holds 0xB and out_valid_o stays 1 for those 5 cycles. 0xC follows after out_ready_i rises.
3. out_ready_i=0, records r0..r5 pushed at edges 0..5 → r0 moves into SEND at edge 1, fifo_level_o reaches 4 at edge 4, r5 is dropped and overflow_count_o=1. Then out_ready_i=1 → r0..r4 emitted in order and r5 never appears.
4. Three records queued, out_ready_i=1 throughout → 9 consecutive valid beats with no bubble, out_last_o on beats 3, 6 and 9.
5. rst_n=0 for one edge immediately after beat 0 is accepted → next cycle out_valid_o=0, fifo_level_o=0, overflow_count_o=0. No beats of that record after release.
6. With GOURAM_TRACE_HEADER_EN:
   - Two records → headers 32'h00000000 and 32'h00000001, each followed by 3 data beats.
   - Force one drop before the third record → its header is 32'h80000002.

Source files
------------

// File: rtl/trace_serialiser.sv
// Trace record serialiser: buffers packed trace records in a small FIFO and emits each one as
// OUT_WIDTH-bit beats (LSB slice first) on a valid/ready stream. Optional header beat: GOURAM_TRACE_HEADER_EN.
`timescale 1ns/1ps

module trace_serialiser #(
  parameter int TRACE_WIDTH = 96,
  parameter int OUT_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             trace_valid_i,
  input  logic [TRACE_WIDTH-1:0]           trace_data_i,
  output logic                             out_valid_o,
  output logic [OUT_WIDTH-1:0]             out_data_o,
  output logic                             out_last_o,
  input  logic                             out_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic [15:0]                      overflow_count_o
);

  localparam int BEATS = (TRACE_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int PAD_W = BEATS * OUT_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic             ONE_BEAT   = (BEATS == 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    SEND
  } state_t;

  logic [TRACE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  state_t                 state;
  logic [PAD_W-1:0]       shreg;
  logic [CNT_W-1:0]       beat_cnt;

  logic                   handshake;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   final_hs;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [PAD_W-1:0]       head_rec;
  logic [PAD_W-1:0]       shifted;

`ifdef GOURAM_TRACE_HEADER_EN
  logic [15:0]            seq;
  logic [15:0]            seq_next;
  logic                   drop_flag;
  logic                   flag_next;
  logic [OUT_WIDTH-1:0]   header_word;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    handshake  = out_valid_o && out_ready_i;
    fifo_empty = (fifo_level_o == '0);
    fifo_full  = (fifo_level_o == FULL_LEVEL);
    final_hs   = (state == SEND) && handshake && out_last_o;
    // A full FIFO still accepts when the head leaves at the same edge.
    pop        = !fifo_empty && ((state == IDLE) || final_hs);
    push       = trace_valid_i && (!fifo_full || pop);
    drop       = trace_valid_i && !push;
    head_rec   = PAD_W'(mem[rd_ptr]);
    shifted    = shreg >> OUT_WIDTH;
  end

`ifdef GOURAM_TRACE_HEADER_EN
  // Header is captured at load time, so it sees the count and drops up to that edge.
  always_comb begin
    seq_next               = seq + 16'(final_hs);
    flag_next              = drop_flag || drop;
    header_word            = '0;
    header_word[15:0]      = seq_next;
    header_word[OUT_WIDTH-1] = flag_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq       <= '0;
      drop_flag <= 1'b0;
    end else begin
      seq <= seq_next;
      if ((state == HDR) && handshake) drop_flag <= drop;
      else                             drop_flag <= flag_next;
    end
  end
`endif

  // NOTE: record storage is deliberately not reset; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trace_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_level_o     <= '0;
      overflow_count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level_o <= fifo_level_o + LVL_W'(push) - LVL_W'(pop);
      if (drop && (overflow_count_o != 16'hFFFF))
        overflow_count_o <= overflow_count_o + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      shreg       <= '0;
      beat_cnt    <= '0;
    end else if (pop) begin
      shreg       <= head_rec;
      beat_cnt    <= '0;
      out_valid_o <= 1'b1;
`ifdef GOURAM_TRACE_HEADER_EN
      state       <= HDR;
      out_data_o  <= header_word;
      out_last_o  <= 1'b0;
`else
      state       <= SEND;
      out_data_o  <= head_rec[OUT_WIDTH-1:0];
      out_last_o  <= ONE_BEAT;
`endif
    end else begin
      case (state)
        IDLE: begin
          out_valid_o <= 1'b0;
        end
        HDR: begin
          if (handshake) begin
            state      <= SEND;
            out_data_o <= shreg[OUT_WIDTH-1:0];
            out_last_o <= ONE_BEAT;
          end
        end
        SEND: begin
          if (handshake) begin
            if (out_last_o) begin
              state       <= IDLE;
              out_valid_o <= 1'b0;
              out_last_o  <= 1'b0;
            end else begin
              shreg      <= shifted;
              out_data_o <= shifted[OUT_WIDTH-1:0];
              beat_cnt   <= beat_cnt + CNT_W'(1);
              out_last_o <= ((beat_cnt + CNT_W'(1)) == LAST_BEAT);
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_o <= 1'b0;
          out_last_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_serialiser.sv
// Self-checking bench for trace_serialiser: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model (header-beat sequence when GOURAM_TRACE_HEADER_EN).
`timescale 1ns/1ps

module tb_trace_serialiser;

  localparam int TW    = 96;
  localparam int OW    = 32;
  localparam int DEPTH = 4;
  localparam int BEATS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trace_valid;
  logic [TW-1:0] trace_data;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic [2:0]    fifo_level;
  logic [15:0]   overflow_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trace_serialiser #(.TRACE_WIDTH(TW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .trace_valid_i    (trace_valid),
    .trace_data_i     (trace_data),
    .out_valid_o      (out_valid),
    .out_data_o       (out_data),
    .out_last_o       (out_last),
    .out_ready_i      (out_ready),
    .fifo_level_o     (fifo_level),
    .overflow_count_o (overflow_count)
  );

  typedef struct {
    logic          push;
    logic [TW-1:0] data;
    logic          ready;
    logic          exp_valid;
    logic [OW-1:0] exp_data;
    logic          exp_last;
    logic [2:0]    exp_level;
  } vec_t;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  vec_t          vecs[$];
  beat_t         exp_q[$];
  logic [TW-1:0] m_q[$];
  beat_t         m_cur[$];
  int            m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(logic push, logic [TW-1:0] data, logic ready,
                                  logic ev, logic [OW-1:0] ed, logic el, logic [2:0] lvl);
    vec_t v;
    v.push = push; v.data = data; v.ready = ready;
    v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_level = lvl;
    vecs.push_back(v);
  endfunction

  function automatic logic [TW-1:0] rand_rec();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void exp_beat(logic [OW-1:0] d, logic l);
    beat_t b;
    b.data = d; b.last = l;
    exp_q.push_back(b);
  endfunction

  function automatic void exp_rec(logic [TW-1:0] r);
    for (int k = 0; k < BEATS; k++) exp_beat(r[k*OW +: OW], k == BEATS - 1);
  endfunction

  // Drains exp_q with out_ready held high, one comparison pair per valid beat.
  task automatic collect(input string tag);
    int budget = 200;
    int idx = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      if (out_valid) begin
        check($sformatf("%s beat%0d data", tag, idx), out_data, exp_q[0].data);
        check($sformatf("%s beat%0d last", tag, idx), out_last, exp_q[0].last);
        void'(exp_q.pop_front());
        idx++;
      end
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      check($sformatf("%s beats missing after timeout", tag), exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Reference model: one clock edge, described as records and beat lists.
  function automatic void model_edge(logic v, logic [TW-1:0] d, logic rdy);
    logic          idle;
    logic          hs;
    logic          last_hs;
    logic          pop;
    logic [TW-1:0] rec;
    beat_t         b;
    idle    = (m_cur.size() == 0);
    hs      = !idle && rdy;
    last_hs = hs && m_cur[0].last;
    if (hs) void'(m_cur.pop_front());
    pop = (m_q.size() > 0) && (idle || last_hs);
    if (pop) begin
      rec = m_q.pop_front();
      for (int k = 0; k < BEATS; k++) begin
        b.data = rec[k*OW +: OW];
        b.last = (k == BEATS - 1);
        m_cur.push_back(b);
      end
    end
    if (v) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else if (m_ovf < 65535) m_ovf++;
    end
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] rec;
    logic [TW-1:0] recs[7];
    logic          v;
    logic          rdy;
    int            pv;
    int            pr;
    int            n;

    rst_n = 1'b0; trace_valid = 1'b0; trace_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_last", out_last, 0);
    check("reset fifo_level", fifo_level, 0);
    check("reset overflow", overflow_count, 0);
    rst_n = 1'b1;

`ifndef GOURAM_TRACE_HEADER_EN
    rec = 96'h0000000C_0000000B_0000000A;
    // Single record at full rate.
    add_vec(1, rec, 1, 0, 32'h0, 0, 0);
    add_vec(0, '0,  1, 0, 32'h0, 0, 1);
    add_vec(0, '0,  1, 1, 32'hA, 0, 0);
    add_vec(0, '0,  1, 1, 32'hB, 0, 0);
    add_vec(0, '0,  1, 1, 32'hC, 1, 0);
    add_vec(0, '0,  1, 0, 32'h0, 0, 0);
    // Same record with a five-cycle stall on beat 1.
    add_vec(1, rec, 1, 0, 32'h0, 0, 0);
    add_vec(0, '0,  1, 0, 32'h0, 0, 1);
    add_vec(0, '0,  1, 1, 32'hA, 0, 0);
    for (int i = 0; i < 5; i++) add_vec(0, '0, 0, 1, 32'hB, 0, 0);
    add_vec(0, '0,  1, 1, 32'hB, 0, 0);
    add_vec(0, '0,  1, 1, 32'hC, 1, 0);
    add_vec(0, '0,  1, 0, 32'h0, 0, 0);

    foreach (vecs[i]) begin
      check($sformatf("vec%0d valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d level", i), fifo_level, vecs[i].exp_level);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d data", i), out_data, vecs[i].exp_data);
        check($sformatf("vec%0d last", i), out_last, vecs[i].exp_last);
      end
      trace_valid = vecs[i].push;
      trace_data  = vecs[i].data;
      out_ready   = vecs[i].ready;
      @(negedge clk);
    end

    // Overflow: six records against a stalled sink, the sixth is dropped.
    for (int i = 0; i < 6; i++) recs[i] = rand_rec();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      trace_valid = 1'b1;
      trace_data  = recs[i];
      @(negedge clk);
      if (i == 1) begin
        check("ovf r0 in send", out_valid, 1);
        check("ovf r0 beat0", out_data, recs[0][OW-1:0]);
      end
      if (i == 4) check("ovf level full", fifo_level, 4);
    end
    trace_valid = 1'b0;
    check("ovf count", overflow_count, 1);
    check("ovf level held", fifo_level, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_rec(recs[i]);
    collect("ovf drain");
    check("ovf idle after drain", out_valid, 0);
    check("ovf level after drain", fifo_level, 0);

    // Three queued records drain back to back with no bubble.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      recs[i] = rand_rec();
      trace_valid = 1'b1;
      trace_data  = recs[i];
      @(negedge clk);
    end
    trace_valid = 1'b0;
    out_ready   = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("b2b beat%0d valid", k), out_valid, 1);
      check($sformatf("b2b beat%0d data", k), out_data, recs[k/3][(k%3)*OW +: OW]);
      check($sformatf("b2b beat%0d last", k), out_last, (k % 3) == 2);
      @(negedge clk);
    end
    check("b2b idle", out_valid, 0);

    // Reset one edge after beat 0 is accepted, with a second record waiting.
    recs[0] = rand_rec();
    recs[1] = rand_rec();
    out_ready = 1'b0;
    trace_valid = 1'b1; trace_data = recs[0]; @(negedge clk);
    trace_valid = 1'b1; trace_data = recs[1]; @(negedge clk);
    trace_valid = 1'b0;
    check("rst beat0 shown", out_data, recs[0][OW-1:0]);
    check("rst level before", fifo_level, 1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst valid cleared", out_valid, 0);
    check("rst level cleared", fifo_level, 0);
    check("rst overflow cleared", overflow_count, 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("rst no stale beats", n, 0);

    // Randomized traffic against the reference model.
    m_q.delete(); m_cur.delete(); m_ovf = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        pv = $urandom_range(20, 95);
        pr = $urandom_range(10, 100);
      end
      check($sformatf("rnd c%0d valid", c), out_valid, m_cur.size() > 0);
      check($sformatf("rnd c%0d level", c), fifo_level, m_q.size());
      check($sformatf("rnd c%0d overflow", c), overflow_count, m_ovf);
      if (m_cur.size() > 0) begin
        check($sformatf("rnd c%0d data", c), out_data, m_cur[0].data);
        check($sformatf("rnd c%0d last", c), out_last, m_cur[0].last);
      end
      v   = ($urandom_range(0, 99) < pv);
      rdy = ($urandom_range(0, 99) < pr);
      rec = rand_rec();
      trace_valid = v;
      trace_data  = rec;
      out_ready   = rdy;
      model_edge(v, rec, rdy);
      @(negedge clk);
    end
    trace_valid = 1'b0;
`else
    for (int i = 0; i < 7; i++) recs[i] = rand_rec();
    // Record 0: header 0 followed by its three data beats.
    out_ready = 1'b1;
    trace_valid = 1'b1; trace_data = recs[0]; @(negedge clk);
    trace_valid = 1'b0;
    exp_beat(32'h00000000, 1'b0);
    exp_rec(recs[0]);
    collect("hdr r0");

    // Record 1: pass its header, then stall on data while the FIFO overflows once.
    out_ready = 1'b0;
    trace_valid = 1'b1; trace_data = recs[1]; @(negedge clk);
    trace_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hdr r1 valid", out_valid, 1);
    check("hdr r1 header", out_data, 32'h00000001);
    check("hdr r1 header last", out_last, 0);
    out_ready = 1'b1; @(negedge clk);
    out_ready = 1'b0;
    check("hdr r1 beat0 shown", out_data, recs[1][OW-1:0]);
    for (int i = 2; i < 7; i++) begin
      trace_valid = 1'b1; trace_data = recs[i]; @(negedge clk);
    end
    trace_valid = 1'b0;
    check("hdr overflow", overflow_count, 1);
    out_ready = 1'b1;
    exp_rec(recs[1]);
    exp_beat(32'h80000002, 1'b0); exp_rec(recs[2]);
    exp_beat(32'h00000003, 1'b0); exp_rec(recs[3]);
    exp_beat(32'h00000004, 1'b0); exp_rec(recs[4]);
    exp_beat(32'h00000005, 1'b0); exp_rec(recs[5]);
    collect("hdr drain");
    check("hdr idle", out_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
